// File: rtl/rad4_pkg.sv
// Shared definitions for the truncated radix-4 Booth multiplier pipeline:
// default parameters, Booth digit encoding and the digit-count derivation.
package rad4_pkg;

    localparam int XW_DEF    = 32;
    localparam int YW_DEF    = 11;
    localparam int TRUNC_DEF = 5;
    localparam int TW_DEF    = 4;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_e;

    // Number of radix-4 digits covering the kept coefficient bits.
    function automatic int rad4_g(input int yw, input int trunc);
        return (yw - trunc) / 2;
    endfunction

endpackage

// File: rtl/rad4_booth_pp.sv
// One radix-4 Booth digit: selects 0, +-X or +-2X of the sample.
// Ports: x_i sample, bits_i digit triplet {hi, mid, lo},
//        pp_o partial product (XW+1 bits, inverted when negative),
//        neg_o sign factor completing the two's complement negation.
module rad4_booth_pp
    import rad4_pkg::*;
#(
    parameter int XW = XW_DEF
) (
    input  logic [XW-1:0] x_i,
    input  logic [2:0]    bits_i,
    output logic [XW:0]   pp_o,
    output logic          neg_o
);

    booth_e      dig;
    logic [XW:0] x1;
    logic [XW:0] x2;

    assign x1 = {x_i[XW-1], x_i};
    assign x2 = {x_i, 1'b0};

    always_comb begin
        unique case (bits_i)
            3'b001, 3'b010: dig = P1;
            3'b011:         dig = P2;
            3'b100:         dig = M2;
            3'b101, 3'b110: dig = M1;
            default:        dig = ZERO;
        endcase
    end

    always_comb begin
        pp_o  = '0;
        neg_o = 1'b0;
        unique case (dig)
            P1: pp_o = x1;
            P2: pp_o = x2;
            M1: begin
                pp_o  = ~x1;
                neg_o = 1'b1;
            end
            M2: begin
                pp_o  = ~x2;
                neg_o = 1'b1;
            end
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/rad4_trunc_mult_pipe.sv
// 3-stage truncated radix-4 Booth multiplier with valid/ready flow control.
// p = floor(x * Yq / 2^(YW-1)) mod 2^XW, Yq = y with TRUNC LSBs cleared.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, x, y, in_tag;
//        out_valid/out_ready, p, out_tag (tag travels with its sample).
module rad4_trunc_mult_pipe
    import rad4_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF,
    parameter int TRUNC = TRUNC_DEF,
    parameter int TW    = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] p,
    output logic [TW-1:0] out_tag
);

    localparam int G  = rad4_g(YW, TRUNC);
    // Sum of digits is scaled by 2^TRUNC; remaining shift to /2^(YW-1).
    localparam int SH = 2 * G - 1;
    localparam int SW = XW + 2 * G;
    localparam logic [YW-1:0] LO_MASK = YW'((64'd1 << TRUNC) - 64'd1);

    // ---------------- S1: Booth encode ----------------
    logic [YW-1:0] yq;
    logic [YW:0]   yqe;
    logic [XW:0]   pp_d [G];
    logic [G-1:0]  neg_d;

    assign yq  = y & ~LO_MASK;
    // Extra zero below yq supplies the "bit below" of the lowest digit.
    assign yqe = {yq, 1'b0};

    for (genvar k = 0; k < G; k++) begin : g_pp
        rad4_booth_pp #(.XW(XW)) u_pp (
            .x_i    (x),
            .bits_i (yqe[TRUNC+2*k +: 3]),
            .pp_o   (pp_d[k]),
            .neg_o  (neg_d[k])
        );
    end

    logic [XW:0]   pp_q [G];
    logic [G-1:0]  neg_q;
    logic [TW-1:0] tag1_q;
    logic          v1_q;

    // ---------------- S2: carry-save reduction ----------------
    logic [SW-1:0] sum_d;
    logic [SW-1:0] car_d;

    always_comb begin
        logic [SW-1:0] t;
        logic [SW-1:0] n;
        logic [SW-1:0] negv;
        negv = '0;
        for (int k = 0; k < G; k++) begin
            negv[2*k] = neg_q[k];
        end
        sum_d = {{(SW-XW-1){pp_q[0][XW]}}, pp_q[0]};
        car_d = negv;
        for (int k = 1; k < G; k++) begin
            t     = {{(SW-XW-1){pp_q[k][XW]}}, pp_q[k]} << (2 * k);
            n     = sum_d ^ car_d ^ t;
            car_d = ((sum_d & car_d) | (sum_d & t) | (car_d & t)) << 1;
            sum_d = n;
        end
    end

    logic [SW-1:0] sum_q;
    logic [SW-1:0] car_q;
    logic [TW-1:0] tag2_q;
    logic          v2_q;

    // ---------------- S3: carry-propagate add + shift ----------------
    logic [SW-1:0] tot_d;
    logic [XW-1:0] p_d;

    assign tot_d = sum_q + car_q;
    assign p_d   = tot_d[SH +: XW];

    logic [XW-1:0] p_q;
    logic [TW-1:0] tag3_q;
    logic          v3_q;

    // ---------------- handshake ----------------
    logic adv1, adv2, adv3, acc;

    assign adv3     = v3_q & out_ready;
    assign adv2     = v2_q & (!v3_q | adv3);
    assign adv1     = v1_q & (!v2_q | adv2);
    assign in_ready = !rst & (!v1_q | adv1);
    assign acc      = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_q   <= '{default: '0};
            neg_q  <= '0;
            tag1_q <= '0;
            v1_q   <= 1'b0;
            sum_q  <= '0;
            car_q  <= '0;
            tag2_q <= '0;
            v2_q   <= 1'b0;
            p_q    <= '0;
            tag3_q <= '0;
            v3_q   <= 1'b0;
        end else begin
            if (acc) begin
                pp_q   <= pp_d;
                neg_q  <= neg_d;
                tag1_q <= in_tag;
            end
            v1_q <= acc | (v1_q & !adv1);
            if (adv1) begin
                sum_q  <= sum_d;
                car_q  <= car_d;
                tag2_q <= tag1_q;
            end
            v2_q <= adv1 | (v2_q & !adv2);
            if (adv2) begin
                p_q    <= p_d;
                tag3_q <= tag2_q;
            end
            v3_q <= adv2 | (v3_q & !adv3);
        end
    end

    assign out_valid = v3_q;
    assign p         = p_q;
    assign out_tag   = tag3_q;

endmodule
